// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Results land in the HI/LO pair under a start/done handshake.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op_mul,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH + 3;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH+1:0] mcand_q, mcand_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] dvnd_q, dvnd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [2:0]       grp;
    logic [WIDTH+1:0] pp;
    logic [WIDTH+1:0] upper;
    logic [PW-1:0]    shifted;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH:0]   rem_fix;

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        dvnd_d  = dvnd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        // prod_q layout: {upper accumulator (W+2), multiplier (W), booth guard bit}
        grp = prod_q[2:0];
        unique case (grp)
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
        upper   = prod_q[PW-1:WIDTH+1] + pp;
        shifted = $signed({upper, prod_q[WIDTH:0]}) >>> 2;

        // Add/subtract choice follows the sign of the remainder before the shift.
        rem_sh  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_nx  = rem_q[WIDTH] ? rem_sh + {1'b0, dvsr_q} : rem_sh - {1'b0, dvsr_q};
        rem_fix = rem_q[WIDTH] ? rem_q + {1'b0, dvsr_q} : rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && (op_mul || op_div)) begin
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
                    cnt_d  = '0;
                    if (op_mul) begin
                        state_d = S_MUL;
                        prod_d  = {{(WIDTH + 2){1'b0}}, b, 1'b0};
                        mcand_d = {{2{a[WIDTH-1]}}, a};
                    end else begin
                        state_d = S_DIV;
                        rem_d   = '0;
                        quo_d   = a[WIDTH-1] ? -a : a;
                        dvsr_d  = b[WIDTH-1] ? -b : b;
                        dvnd_d  = a;
                        qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                        rneg_d  = a[WIDTH-1];
                    end
                end
            end
            S_MUL: begin
                prod_d = shifted;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH / 2 - 1)) begin
                    hi_d    = shifted[2*WIDTH:WIDTH+1];
                    lo_d    = shifted[WIDTH:1];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                if (cnt_q == '0 && dvsr_q == '0) begin
                    hi_d    = dvnd_q;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = {quo_q[WIDTH-2:0], ~rem_nx[WIDTH]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = rneg_q ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
                lo_d    = qneg_q ? -quo_q : quo_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            dvnd_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            dvnd_q  <= dvnd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32 and WIDTH=8.
module tb_mul_div_unit;

    logic        clk;
    logic        clr;

    logic        start32, mul32, div32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dbz32;
    logic [31:0] hi32, lo32;

    logic        start8, mul8, div8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int seen;

    mul_div_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .clr(clr), .start(start32), .op_mul(mul32), .op_div(div32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .div_by_zero(dbz32),
        .hi(hi32), .lo(lo32)
    );

    mul_div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .clr(clr), .start(start8), .op_mul(mul8), .op_div(div8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div_by_zero(dbz8),
        .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge (T0) accepts the request.
    task automatic issue32(input logic m, input logic d, input logic [31:0] x, input logic [31:0] y);
        start32 = 1'b1; mul32 = m; div32 = d; a32 = x; b32 = y;
        @(negedge clk);
        start32 = 1'b0; mul32 = 1'b0; div32 = 1'b0;
        a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D;
    endtask

    // Returns the number of edges after T0 until done is seen (bounded).
    // poke>0 pulses a MUL start in that cycle, which must be ignored.
    task automatic wait32(input int poke, output int n);
        n = 0;
        while (!done32 && n < 100) begin
            @(negedge clk);
            n++;
            if (poke != 0 && n == poke) begin
                start32 = 1'b1; mul32 = 1'b1; a32 = 32'd5; b32 = 32'd5;
            end else begin
                start32 = 1'b0; mul32 = 1'b0;
            end
        end
        start32 = 1'b0; mul32 = 1'b0;
    endtask

    task automatic issue8(input logic m, input logic d, input logic [7:0] x, input logic [7:0] y);
        start8 = 1'b1; mul8 = m; div8 = d; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0; mul8 = 1'b0; div8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        clr = 1'b1;
        start32 = 0; mul32 = 0; div32 = 0; a32 = '0; b32 = '0;
        start8 = 0; mul8 = 0; div8 = 0; a8 = '0; b8 = '0;
        #12;
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_dbz", 64'(dbz32), 64'd0);
        check("rst_hilo", {hi32, lo32}, 64'd0);
        check("rst_hilo8", 64'({busy8, done8, dbz8, hi8, lo8}), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        issue32(1, 0, 32'd7, -32'sd3);
        check("mul_busy", 64'(busy32), 64'd1);
        wait32(0, cyc);
        check("mul_lat", 64'(cyc), 64'd16);
        check("mul_7x-3", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFEB);
        @(negedge clk);
        check("done_width", 64'(done32), 64'd0);

        issue32(1, 0, 32'h8000_0000, 32'h8000_0000);
        check("hold_lo", 64'(lo32), 64'h0000_0000_FFFF_FFEB);
        wait32(0, cyc);
        check("mul_min_sq", {hi32, lo32}, 64'h40000000_00000000);

        issue32(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait32(0, cyc);
        check("mul_max_sq", {hi32, lo32}, 64'h3FFFFFFF_00000001);

        issue32(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32(0, cyc);
        check("mul_both_ops", {hi32, lo32}, 64'h00000000_00000001);

        issue32(0, 1, 32'd100, 32'd7);
        wait32(5, cyc);
        check("div_lat", 64'(cyc), 64'd33);
        check("div_100/7", {hi32, lo32}, 64'h00000002_0000000E);
        check("div_noflag", 64'(dbz32), 64'd0);

        issue32(0, 1, -32'sd100, 32'd7);
        wait32(0, cyc);
        check("div_-100/7", {hi32, lo32}, 64'hFFFFFFFE_FFFFFFF2);

        issue32(0, 1, 32'd100, -32'sd7);
        wait32(0, cyc);
        check("div_100/-7", {hi32, lo32}, 64'h00000002_FFFFFFF2);

        issue32(0, 1, 32'h0000_1234, 32'd0);
        wait32(0, cyc);
        check("dbz_lat", 64'(cyc), 64'd1);
        check("dbz_flag", 64'(dbz32), 64'd1);
        check("dbz_result", {hi32, lo32}, 64'h00001234_FFFFFFFF);
        @(negedge clk);
        check("dbz_held", 64'(dbz32), 64'd1);

        // start with no op bit set must not launch anything
        start32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
        @(negedge clk);
        start32 = 1'b0;
        check("noop_busy", 64'(busy32), 64'd0);

        issue32(1, 0, 32'd6, -32'sd6);
        check("dbz_cleared", 64'(dbz32), 64'd0);
        wait32(0, cyc);
        check("mul_6x-6", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFDC);

        // abandon a divide with clr mid-flight
        issue32(0, 1, 32'd1000, 32'd3);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start32 = 1'b1; mul32 = 1'b1; a32 = 32'd2; b32 = 32'd2;
            end else begin
                start32 = 1'b0; mul32 = 1'b0;
            end
        end
        check("poke_busy", 64'(busy32), 64'd1);
        #1 clr = 1'b1;
        #1;
        check("clr_async", {28'd0, busy32, done32, dbz32, 1'b0, hi32}, 64'd0);
        check("clr_lo", 64'(lo32), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32) seen++;
        end
        check("clr_no_done", 64'(seen), 64'd0);

        issue32(1, 0, 32'd3, 32'd4);
        wait32(0, cyc);
        check("mul_3x4", {hi32, lo32}, 64'h00000000_0000000C);

        issue8(1, 0, 8'h80, 8'hFF);
        wait8(cyc);
        check("w8_mul_lat", 64'(cyc), 64'd4);
        check("w8_mul", 64'({hi8, lo8}), 64'h0080);
        issue8(0, 1, 8'h80, 8'hFF);
        check("w8_b2b_busy", 64'(busy8), 64'd1);
        check("w8_b2b_done", 64'(done8), 64'd0);
        wait8(cyc);
        check("w8_div_lat", 64'(cyc), 64'd9);
        check("w8_div", 64'({hi8, lo8}), 64'h0080);
        check("w8_div_flag", 64'(dbz8), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
